// File: rtl/drinks_pkg.sv
// rtl/drinks_pkg.sv - shared types and constants for the change dispenser
package drinks_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  // Coin select codes double as the refill_sel encoding
  typedef enum logic [1:0] {
    SEL_1    = 2'b00,
    SEL_2    = 2'b01,
    SEL_4    = 2'b10,
    SEL_NONE = 2'b11
  } coin_sel_t;

  localparam logic [3:0] DENOM_1 = 4'd1;
  localparam logic [3:0] DENOM_2 = 4'd2;
  localparam logic [3:0] DENOM_4 = 4'd4;

  function automatic logic [3:0] denom_of(coin_sel_t sel);
    case (sel)
      SEL_1:   return DENOM_1;
      SEL_2:   return DENOM_2;
      SEL_4:   return DENOM_4;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_ctrl_if.sv
// rtl/change_dispenser_ctrl_if.sv - request, hopper, refill and status bundle
interface change_dispenser_ctrl_if;
  logic       req_valid;
  logic [3:0] req_amount;
  logic       req_ready;
  logic       eject_1;
  logic       eject_2;
  logic       eject_4;
  logic       hopper_ack;
  logic       refill_valid;
  logic [1:0] refill_sel;
  logic [3:0] refill_count;
  logic [3:0] cnt_1;
  logic [3:0] cnt_2;
  logic [3:0] cnt_4;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] shortfall;

  modport master (
    output req_valid, req_amount, hopper_ack, refill_valid, refill_sel, refill_count,
    input  req_ready, eject_1, eject_2, eject_4, cnt_1, cnt_2, cnt_4, busy, done, err, shortfall
  );

  modport slave (
    input  req_valid, req_amount, hopper_ack, refill_valid, refill_sel, refill_count,
    output req_ready, eject_1, eject_2, eject_4, cnt_1, cnt_2, cnt_4, busy, done, err, shortfall
  );
endinterface

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - three saturating coin counters with refill and decrement
module coin_inventory
  import drinks_pkg::*;
#(
  parameter int INIT_COUNT = 4
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       refill_valid,
  input  logic [1:0] refill_sel,
  input  logic [3:0] refill_count,
  input  logic       dec_valid,
  input  coin_sel_t  dec_sel,
  output logic [3:0] cnt_1,
  output logic [3:0] cnt_2,
  output logic [3:0] cnt_4
);

  localparam logic [3:0] INIT_VAL = 4'(INIT_COUNT);

  // 5-bit sum so a simultaneous decrement and refill saturate correctly
  function automatic logic [3:0] next_count(logic [3:0] cnt, logic dec, logic [3:0] add);
    logic [4:0] sum;
    sum = {1'b0, cnt} + {1'b0, add} - {4'd0, dec && (cnt != 4'd0)};
    return (sum > 5'd15) ? 4'd15 : sum[3:0];
  endfunction

  logic [3:0] add_1, add_2, add_4;

  always_comb begin
    add_1 = (refill_valid && refill_sel == SEL_1) ? refill_count : 4'd0;
    add_2 = (refill_valid && refill_sel == SEL_2) ? refill_count : 4'd0;
    add_4 = (refill_valid && refill_sel == SEL_4) ? refill_count : 4'd0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_1 <= INIT_VAL;
      cnt_2 <= INIT_VAL;
      cnt_4 <= INIT_VAL;
    end else begin
      cnt_1 <= next_count(cnt_1, dec_valid && dec_sel == SEL_1, add_1);
      cnt_2 <= next_count(cnt_2, dec_valid && dec_sel == SEL_2, add_2);
      cnt_4 <= next_count(cnt_4, dec_valid && dec_sel == SEL_4, add_4);
    end
  end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// rtl/change_dispenser_ctrl.sv - greedy change dispenser FSM with hopper handshake
module change_dispenser_ctrl
  import drinks_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int INIT_COUNT  = 4
) (
  input logic                   CLK,
  input logic                   reset_n,
  change_dispenser_ctrl_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  coin_sel_t  sel_q, sel_d;
  logic [3:0] remaining_q, remaining_d;
  logic [3:0] shortfall_q, shortfall_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       ack_take;
  logic [3:0] cnt_1, cnt_2, cnt_4;

  coin_inventory #(.INIT_COUNT(INIT_COUNT)) u_inventory (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .refill_valid (bus.refill_valid),
    .refill_sel   (bus.refill_sel),
    .refill_count (bus.refill_count),
    .dec_valid    (ack_take),
    .dec_sel      (sel_q),
    .cnt_1        (cnt_1),
    .cnt_2        (cnt_2),
    .cnt_4        (cnt_4)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= SEL_NONE;
      remaining_q <= 4'd0;
      shortfall_q <= 4'd0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    tmo_d       = tmo_q;
    ack_take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          remaining_d = bus.req_amount;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == 4'd0) begin
          state_d = DONE;
        end else if (remaining_q >= DENOM_4 && cnt_4 != 4'd0) begin
          sel_d   = SEL_4;
          state_d = EJECT;
        end else if (remaining_q >= DENOM_2 && cnt_2 != 4'd0) begin
          sel_d   = SEL_2;
          state_d = EJECT;
        end else if (cnt_1 != 4'd0) begin
          sel_d   = SEL_1;
          state_d = EJECT;
        end else begin
          state_d = FAULT;
        end
      end
      EJECT: begin
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack in the last allowed cycle takes priority over the timeout
        if (bus.hopper_ack) begin
          ack_take    = 1'b1;
          remaining_d = remaining_q - denom_of(sel_q);
          tmo_d       = '0;
          state_d     = SELECT;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        shortfall_d = 4'd0;
        state_d     = IDLE;
      end
      FAULT: begin
        shortfall_d = remaining_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE) || (state_q == FAULT);
  assign bus.err       = (state_q == FAULT);
  assign bus.eject_1   = (state_q == EJECT) && (sel_q == SEL_1);
  assign bus.eject_2   = (state_q == EJECT) && (sel_q == SEL_2);
  assign bus.eject_4   = (state_q == EJECT) && (sel_q == SEL_4);
  assign bus.cnt_1     = cnt_1;
  assign bus.cnt_2     = cnt_2;
  assign bus.cnt_4     = cnt_4;
  assign bus.shortfall = shortfall_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// tb/tb_change_dispenser_ctrl.sv - randomized self-checking bench with greedy change model
module tb_change_dispenser_ctrl;

  logic CLK = 1'b0;
  logic reset_n;
  always #5 CLK = ~CLK;

  change_dispenser_ctrl_if bus();

  change_dispenser_ctrl #(.ACK_TIMEOUT(15), .INIT_COUNT(4)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model inventory: [0]=1-ruble, [1]=2-ruble, [2]=4-ruble
  int m_cnt[3];

  longint     obs_sig;
  int         obs_done_cyc, obs_first;
  bit         obs_err, obs_multi;
  logic [3:0] obs_short;
  logic [11:0] obs_cnt;

  longint exp_sig;
  bit     exp_err;
  int     exp_short;

  function automatic logic [11:0] m_pack();
    return {4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
  endfunction

  function automatic int sat15(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_refill(input int sel, input int count);
    if (sel < 3) m_cnt[sel] = sat15(m_cnt[sel] + count);
  endtask

  // Greedy payout; the coin sequence is folded into a base-5 signature
  task automatic model_run(input int amount, input bit acks);
    int rem, d, idx;
    bit fin;
    rem = amount; exp_sig = 0; fin = 0; exp_err = 0; exp_short = 0;
    while (!fin) begin
      if (rem == 0) begin
        fin = 1;
      end else begin
        if (rem >= 4 && m_cnt[2] > 0)      begin d = 4; idx = 2; end
        else if (rem >= 2 && m_cnt[1] > 0) begin d = 2; idx = 1; end
        else if (m_cnt[0] > 0)             begin d = 1; idx = 0; end
        else                               begin d = 0; idx = 0; end
        if (d == 0) begin
          exp_err = 1; exp_short = rem; fin = 1;
        end else begin
          exp_sig = exp_sig * 5 + d;
          if (!acks) begin
            exp_err = 1; exp_short = rem; fin = 1;
          end else begin
            rem = rem - d;
            m_cnt[idx] = m_cnt[idx] - 1;
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = 0; bus.req_amount = 0; bus.hopper_ack = 0;
    bus.refill_valid = 0; bus.refill_sel = 0; bus.refill_count = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    clear_inputs();
    @(posedge CLK); #1;
    reset_n = 1;
    m_cnt = '{4, 4, 4};
    @(posedge CLK); #1;
  endtask

  task automatic do_refill(input int sel, input int count);
    @(posedge CLK); #1;
    bus.refill_valid = 1; bus.refill_sel = 2'(sel); bus.refill_count = 4'(count);
    @(posedge CLK); #1;
    bus.refill_valid = 0;
    model_refill(sel, count);
  endtask

  // Drives one request and records what the DUT did; ack_delay 0 means never ack
  task automatic run_req(input int amount, input int ack_delay, input int refill_on_ack);
    int ack_at, n_ej, d;
    obs_sig = 0; obs_done_cyc = -1; obs_first = -1; obs_err = 0; obs_multi = 0;
    ack_at = -1;
    @(posedge CLK); #1;
    bus.req_valid = 1; bus.req_amount = 4'(amount);
    for (int k = 1; k <= 80; k++) begin
      @(posedge CLK); #1;
      bus.req_valid = 0;
      bus.hopper_ack = (k == ack_at);
      bus.refill_valid = (k == ack_at) && (refill_on_ack > 0);
      bus.refill_sel = 2'b00;
      bus.refill_count = 4'(refill_on_ack);
      n_ej = int'(bus.eject_1) + int'(bus.eject_2) + int'(bus.eject_4);
      if (n_ej > 1) obs_multi = 1;
      if (n_ej == 1) begin
        d = bus.eject_4 ? 4 : (bus.eject_2 ? 2 : 1);
        obs_sig = obs_sig * 5 + d;
        if (obs_first < 0) obs_first = k;
        if (ack_delay > 0) ack_at = k + ack_delay;
      end
      if (bus.done) begin
        obs_done_cyc = k; obs_err = bus.err;
        break;
      end
    end
    bus.hopper_ack = 0; bus.refill_valid = 0;
    @(posedge CLK); #1;
    obs_short = bus.shortfall;
    obs_cnt = {bus.cnt_4, bus.cnt_2, bus.cnt_1};
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({bus.eject_1, bus.eject_2, bus.eject_4, bus.done, bus.err, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=000000",
        {bus.eject_1, bus.eject_2, bus.eject_4, bus.done, bus.err, bus.busy});
    end
    reset_n = 1;
    m_cnt = '{4, 4, 4};
    @(posedge CLK); #1;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    total++;
    if ({bus.cnt_4, bus.cnt_2, bus.cnt_1} !== 12'h444) begin
      bad++; $display("FAIL reset_counts got=%h exp=444", {bus.cnt_4, bus.cnt_2, bus.cnt_1});
    end
    total++;
    if (bus.shortfall !== 4'd0) begin bad++; $display("FAIL reset_shortfall got=%0d exp=0", bus.shortfall); end
  endtask

  task automatic test_greedy();
    model_run(7, 1);
    run_req(7, 2, 0);
    total++;
    if (obs_sig !== exp_sig) begin bad++; $display("FAIL greedy_seq got=%0d exp=%0d", obs_sig, exp_sig); end
    total++;
    if (obs_first !== 2) begin bad++; $display("FAIL greedy_first_eject got=%0d exp=2", obs_first); end
    total++;
    if (obs_done_cyc < 0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL greedy_done got=%0d/%b exp=done/0", obs_done_cyc, obs_err);
    end
    total++;
    if (obs_cnt !== 12'h333 || obs_cnt !== m_pack()) begin
      bad++; $display("FAIL greedy_counts got=%h exp=333", obs_cnt);
    end
    total++;
    if (obs_multi) begin bad++; $display("FAIL greedy_one_hot got=multi exp=single"); end
  endtask

  task automatic test_zero_amount();
    model_run(0, 1);
    run_req(0, 1, 0);
    total++;
    if (obs_done_cyc !== 2 || obs_sig !== 0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL zero_amount got=cyc%0d/sig%0d/err%b exp=cyc2/sig0/err0", obs_done_cyc, obs_sig, obs_err);
    end
  endtask

  task automatic test_twos_and_shortfall();
    apply_reset();
    repeat (4) begin model_run(4, 1); run_req(4, 1, 0); end
    model_run(6, 1);
    run_req(6, 1, 0);
    total++;
    if (obs_sig !== exp_sig || obs_sig !== 62) begin bad++; $display("FAIL twos_seq got=%0d exp=%0d", obs_sig, exp_sig); end
    total++;
    if (obs_err !== 1'b0 || obs_cnt[7:4] !== 4'd1) begin
      bad++; $display("FAIL twos_result got=err%b/cnt2=%0d exp=err0/cnt2=1", obs_err, obs_cnt[7:4]);
    end
    repeat (4) begin model_run(1, 1); run_req(1, 1, 0); end
    model_run(3, 1);
    run_req(3, 2, 0);
    total++;
    if (obs_sig !== exp_sig || obs_err !== 1'b1) begin
      bad++; $display("FAIL shortfall_seq got=%0d/err%b exp=%0d/err1", obs_sig, obs_err, exp_sig);
    end
    total++;
    if (obs_short !== 4'(exp_short) || obs_short !== 4'd1) begin
      bad++; $display("FAIL shortfall_value got=%0d exp=1", obs_short);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    model_run(5, 0);
    run_req(5, 0, 0);
    total++;
    if (obs_sig !== 4 || obs_done_cyc !== 18) begin
      bad++; $display("FAIL timeout_timing got=sig%0d/cyc%0d exp=sig4/cyc18", obs_sig, obs_done_cyc);
    end
    total++;
    if (obs_err !== 1'b1 || obs_short !== 4'd5 || obs_cnt !== m_pack()) begin
      bad++; $display("FAIL timeout_result got=err%b/short%0d/cnt%h exp=err1/short5/cnt%h", obs_err, obs_short, obs_cnt, m_pack());
    end
    model_run(1, 1);
    run_req(1, 15, 0);
    total++;
    if (obs_err !== 1'b0 || obs_done_cyc !== 19 || obs_cnt !== m_pack()) begin
      bad++; $display("FAIL ack_last_cycle got=err%b/cyc%0d/cnt%h exp=err0/cyc19/cnt%h", obs_err, obs_done_cyc, obs_cnt, m_pack());
    end
    model_run(1, 0);
    run_req(1, 16, 0);
    total++;
    if (obs_err !== 1'b1 || obs_done_cyc !== 18 || obs_cnt !== m_pack()) begin
      bad++; $display("FAIL ack_too_late got=err%b/cyc%0d/cnt%h exp=err1/cyc18/cnt%h", obs_err, obs_done_cyc, obs_cnt, m_pack());
    end
  endtask

  task automatic test_refill_saturate();
    apply_reset();
    do_refill(0, 10);
    run_req(1, 1, 9);
    m_cnt[0] = sat15(m_cnt[0] - 1 + 9);
    total++;
    if (obs_cnt[3:0] !== 4'd15 || obs_err !== 1'b0) begin
      bad++; $display("FAIL refill_with_ack got=cnt1=%0d/err%b exp=cnt1=15/err0", obs_cnt[3:0], obs_err);
    end
    do_refill(1, 15);
    do_refill(3, 7);
    @(posedge CLK); #1;
    total++;
    if ({bus.cnt_4, bus.cnt_2, bus.cnt_1} !== m_pack()) begin
      bad++; $display("FAIL refill_idle got=%h exp=%h", {bus.cnt_4, bus.cnt_2, bus.cnt_1}, m_pack());
    end
  endtask

  task automatic test_ack_outside_wait();
    @(posedge CLK); #1;
    bus.hopper_ack = 1;
    repeat (3) @(posedge CLK);
    #1;
    bus.hopper_ack = 0;
    total++;
    if ({bus.cnt_4, bus.cnt_2, bus.cnt_1} !== m_pack() || bus.busy !== 1'b0) begin
      bad++; $display("FAIL stray_ack got=%h/busy%b exp=%h/busy0", {bus.cnt_4, bus.cnt_2, bus.cnt_1}, bus.busy, m_pack());
    end
  endtask

  task automatic test_reset_mid_request();
    bit done_seen;
    apply_reset();
    do_refill(2, 3);
    @(posedge CLK); #1;
    bus.req_valid = 1; bus.req_amount = 4'd5;
    @(posedge CLK); #1;
    bus.req_valid = 0;
    repeat (4) @(posedge CLK);
    #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL midreq_busy got=%b exp=1", bus.busy); end
    reset_n = 0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL async_reset got=busy%b/done%b exp=busy0/done0", bus.busy, bus.done);
    end
    done_seen = 0;
    repeat (2) begin @(posedge CLK); #1; if (bus.done) done_seen = 1; end
    reset_n = 1;
    m_cnt = '{4, 4, 4};
    repeat (3) begin @(posedge CLK); #1; if (bus.done) done_seen = 1; end
    total++;
    if (done_seen || bus.req_ready !== 1'b1 || {bus.cnt_4, bus.cnt_2, bus.cnt_1} !== 12'h444) begin
      bad++; $display("FAIL midreq_abort got=done%b/ready%b/cnt%h exp=done0/ready1/cnt444",
        done_seen, bus.req_ready, {bus.cnt_4, bus.cnt_2, bus.cnt_1});
    end
  endtask

  task automatic test_random();
    int amt, dly;
    bit noack;
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) do_refill($urandom_range(0, 3), $urandom_range(0, 6));
      amt = $urandom_range(0, 15);
      dly = $urandom_range(1, 4);
      noack = ($urandom_range(0, 5) == 0);
      model_run(amt, !noack);
      run_req(amt, noack ? 0 : dly, 0);
      total++;
      if (obs_sig !== exp_sig || obs_err !== exp_err || obs_short !== 4'(exp_short) || obs_cnt !== m_pack() || obs_multi) begin
        bad++; $display("FAIL random_%0d amt=%0d got=sig%0d/err%b/short%0d/cnt%h exp=sig%0d/err%b/short%0d/cnt%h",
          i, amt, obs_sig, obs_err, obs_short, obs_cnt, exp_sig, exp_err, exp_short, m_pack());
      end
    end
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_zero_amount();
    test_ack_outside_wait();
    test_twos_and_shortfall();
    test_timeout();
    test_refill_saturate();
    test_reset_mid_request();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser_ctrl.md
CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles spent in WAIT_ACK without hopper_ack before fault.
REQ-002 Parameter INIT_COUNT, default 4, coin count loaded into each inventory counter at reset.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 req_valid  input  1  change request present.
REQ-006 req_amount  input  4  change owed in rubles, 0..15.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 eject_1 / eject_2 / eject_4  output  1 each  one-cycle command to hopper to eject one 1/2/4-ruble coin.
REQ-009 hopper_ack  input  1  hopper confirms the last ejected coin left.
REQ-010 refill_valid  input  1  add coins to inventory this cycle.
REQ-011 refill_sel  input  2  00=1-ruble, 01=2-ruble, 10=4-ruble, 11=ignored.
REQ-012 refill_count  input  4  coins added.
REQ-013 cnt_1 / cnt_2 / cnt_4  output  4 each  current coin inventory.
REQ-014 busy  output  1  state != IDLE.
REQ-015 done  output  1  one-cycle pulse at end of every accepted request.
REQ-016 err  output  1  valid with done; 1 = change not fully paid.
REQ-017 shortfall  output  4  rubles left unpaid at last done; held until next done.

Function
REQ-018 States SHALL be IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
REQ-019 req_ready SHALL equal (state == IDLE); handshake completes on req_valid & req_ready; remaining <= req_amount; next state SELECT.
REQ-020 SELECT: remaining==0 -> DONE; else pick largest d in {4,2,1} with d <= remaining and cnt_d > 0 -> EJECT; none -> FAULT.
REQ-021 EJECT: assert the selected eject_d for exactly one cycle -> WAIT_ACK; at most one eject_* high in any cycle.
REQ-022 WAIT_ACK: on hopper_ack, remaining -= d, cnt_d -= 1, timeout counter cleared -> SELECT.
REQ-023 WAIT_ACK: ACK_TIMEOUT cycles without hopper_ack -> FAULT; ack in the final cycle wins over timeout.
REQ-024 hopper_ack outside WAIT_ACK SHALL be ignored.
REQ-025 DONE: done=1, err=0, shortfall<=0 -> IDLE.
REQ-026 FAULT: done=1, err=1, shortfall<=remaining -> IDLE.
REQ-027 Latency: accept at cycle 0; first eject at cycle 2; amount 0 gives done at cycle 2 with no eject.
REQ-028 Refill SHALL be accepted in any state; cnt_sel <= min(15, cnt_sel + refill_count).
REQ-029 Refill and ack decrement on the same counter in one cycle: cnt <= min(15, cnt - 1 + refill_count).
REQ-030 Refill during SELECT SHALL be visible to that cycle's selection only from the next cycle.
REQ-031 Counter arithmetic SHALL be 5-bit internally; no wrap below 0 (decrement only when cnt > 0).

Reset
REQ-032 reset_n low: state IDLE, cnt_1/2/4 = INIT_COUNT, remaining 0, timeout counter 0, shortfall 0.
REQ-033 During reset all eject_*, done, err, busy SHALL be 0; req_ready SHALL be 1 after release.
REQ-034 Reset mid-request SHALL abort silently: no done pulse, inventory reinitialised.

Structure
REQ-035 Shared package drinks_pkg SHALL hold the state enum, coin denomination constants (1,2,4) and refill_sel encodings.
REQ-036 Sub-module coin_inventory SHALL hold the three saturating counters with refill/decrement ports.

Verification
REQ-037 Counts 4/4/4, amount 7, ack 2 cycles after each eject -> eject_4, eject_2, eject_1; done, err=0; counts 3/3/3.
REQ-038 cnt_4=0, cnt_2=4, amount 6 -> three eject_2; done err=0; cnt_2=1.
REQ-039 cnt_1=0, cnt_2=1, cnt_4=0, amount 3 -> one eject_2, then done err=1, shortfall=1.
REQ-040 Amount 5, hopper_ack never asserted -> eject_4, FAULT after 15 WAIT_ACK cycles, shortfall=5, cnt_4 unchanged.
REQ-041 cnt_1=14, refill_sel=00, refill_count=9 same cycle as ack on a 1-ruble eject -> cnt_1=15.
REQ-042 reset_n low during WAIT_ACK -> no done, all counts=4, req_ready=1 after release.
